// File: rtl/peripheral_dbg_soc_mam_ahb3_arbiter.sv
// ---------------------------------------------------------------------------
// peripheral_dbg_soc_mam_ahb3_arbiter
//
// Two-master AHB3 arbiter that places the debug memory access module (MAM)
// and the CPU in front of a single memory slave. The MAM has fixed priority.
// The CPU is protected by a hold counter: it may keep ownership for at most
// CPU_HOLD_MAX cycles while the MAM waits.
//
// Address-phase signals go combinationally from the current owner. Data-phase
// signals (hwdata out; hrdata/hready/hresp back) follow a registered
// data-phase owner, so a handover never tears a transfer that is in flight.
// Master index 0 is the CPU and index 1 is the MAM in the per-master vectors.
// ---------------------------------------------------------------------------
module peripheral_dbg_soc_mam_ahb3_arbiter #(
    parameter int PLEN         = 32,
    parameter int XLEN         = 32,
    parameter int CPU_HOLD_MAX = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    // CPU master
    input  logic              cpu_hsel_i,
    input  logic [PLEN-1:0]   cpu_haddr_i,
    input  logic [XLEN-1:0]   cpu_hwdata_i,
    input  logic              cpu_hwrite_i,
    input  logic [2:0]        cpu_hsize_i,
    input  logic [2:0]        cpu_hburst_i,
    input  logic [XLEN/8-1:0] cpu_hprot_i,
    input  logic [1:0]        cpu_htrans_i,
    input  logic              cpu_hmastlock_i,
    output logic [XLEN-1:0]   cpu_hrdata_o,
    output logic              cpu_hready_o,
    output logic              cpu_hresp_o,

    // MAM master
    input  logic              mam_hsel_i,
    input  logic [PLEN-1:0]   mam_haddr_i,
    input  logic [XLEN-1:0]   mam_hwdata_i,
    input  logic              mam_hwrite_i,
    input  logic [2:0]        mam_hsize_i,
    input  logic [2:0]        mam_hburst_i,
    input  logic [XLEN/8-1:0] mam_hprot_i,
    input  logic [1:0]        mam_htrans_i,
    input  logic              mam_hmastlock_i,
    output logic [XLEN-1:0]   mam_hrdata_o,
    output logic              mam_hready_o,
    output logic              mam_hresp_o,

    // Memory slave
    output logic              mem_hsel_o,
    output logic [PLEN-1:0]   mem_haddr_o,
    output logic [XLEN-1:0]   mem_hwdata_o,
    output logic              mem_hwrite_o,
    output logic [2:0]        mem_hsize_o,
    output logic [2:0]        mem_hburst_o,
    output logic [XLEN/8-1:0] mem_hprot_o,
    output logic [1:0]        mem_htrans_o,
    output logic              mem_hmastlock_o,
    input  logic [XLEN-1:0]   mem_hrdata_i,
    input  logic              mem_hready_i,
    input  logic              mem_hresp_i,

    // Current address-phase owner
    output logic              grant_cpu_o,
    output logic              grant_mam_o
);

    localparam int SW = XLEN / 8;

    // Address-phase ownership states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAM  = 2'd1;
    localparam logic [1:0] ST_CPU  = 2'd2;

    // Data-phase owner encoding
    localparam logic [1:0] DP_NONE = 2'd0;
    localparam logic [1:0] DP_CPU  = 2'd1;
    localparam logic [1:0] DP_MAM  = 2'd2;

    // AHB transfer types
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [7:0] HOLD_MAX = 8'(CPU_HOLD_MAX);

    logic [1:0] state_reg, state_next;
    logic [1:0] dphase_reg, dphase_next;
    logic [7:0] hold_cnt_reg, hold_cnt_next;

    logic       cpu_req;
    logic       mam_req;
    logic       own_lock;
    logic [1:0] own_trans;
    logic       boundary;
    logic       hold_at_max;

    // Per-master views (index 0 = CPU, 1 = MAM)
    logic [1:0]      req_vec;
    logic [1:0]      aowner_vec;
    logic [1:0]      downer_vec;
    logic [1:0]      hready_vec;
    logic [1:0]      hresp_vec;
    logic [XLEN-1:0] hrdata_arr [2];

    // A master requests when selected with a NONSEQ or SEQ transfer
    assign cpu_req = cpu_hsel_i & cpu_htrans_i[1];
    assign mam_req = mam_hsel_i & mam_htrans_i[1];

    assign hold_at_max = (hold_cnt_reg >= HOLD_MAX);

    // Lock and transfer type of the current owner, used for boundary detection
    always_comb begin
        own_lock  = 1'b0;
        own_trans = HTRANS_IDLE;
        case (state_reg)
            ST_CPU: begin
                own_lock  = cpu_hmastlock_i;
                own_trans = cpu_htrans_i;
            end
            ST_MAM: begin
                own_lock  = mam_hmastlock_i;
                own_trans = mam_htrans_i;
            end
            default: ;
        endcase
    end

    // Ownership may only move between bursts and outside locked sequences
    assign boundary = mem_hready_i & ~own_lock &
                      (own_trans != HTRANS_SEQ) & (own_trans != HTRANS_BUSY);

    // Ownership transitions; the MAM wins ties, the CPU is pre-empted once its hold budget is spent
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mem_hready_i) begin
                    if (mam_req)
                        state_next = ST_MAM;
                    else if (cpu_req)
                        state_next = ST_CPU;
                end
            end
            ST_MAM: begin
                if (boundary && !mam_req) begin
                    if (cpu_req)
                        state_next = ST_CPU;
                    else
                        state_next = ST_IDLE;
                end
            end
            ST_CPU: begin
                if (boundary) begin
                    if (mam_req && (!cpu_req || hold_at_max))
                        state_next = ST_MAM;
                    else if (!mam_req && !cpu_req)
                        state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Hold counter: counts CPU-owned cycles during which the MAM is kept waiting
    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (state_next == ST_CPU && state_reg != ST_CPU)
            hold_cnt_next = 8'd0;
        else if (!mam_req)
            hold_cnt_next = 8'd0;
        else if (state_reg == ST_CPU && !hold_at_max)
            hold_cnt_next = hold_cnt_reg + 8'd1;
    end

    // Data-phase owner: whoever had a transfer accepted in this address phase
    always_comb begin
        dphase_next = dphase_reg;
        if (mem_hready_i) begin
            if (state_reg == ST_CPU && cpu_req)
                dphase_next = DP_CPU;
            else if (state_reg == ST_MAM && mam_req)
                dphase_next = DP_MAM;
            else
                dphase_next = DP_NONE;
        end
    end

    // State registers; reset abandons any transfer in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ST_IDLE;
            dphase_reg   <= DP_NONE;
            hold_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            dphase_reg   <= dphase_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign grant_cpu_o = (state_reg == ST_CPU);
    assign grant_mam_o = (state_reg == ST_MAM);

    // Address-phase mux from the owner; nothing is presented while idle
    always_comb begin
        mem_hsel_o      = 1'b0;
        mem_haddr_o     = '0;
        mem_hwrite_o    = 1'b0;
        mem_hsize_o     = 3'b000;
        mem_hburst_o    = 3'b000;
        mem_hprot_o     = '0;
        mem_htrans_o    = HTRANS_IDLE;
        mem_hmastlock_o = 1'b0;
        case (state_reg)
            ST_CPU: begin
                mem_hsel_o      = cpu_hsel_i;
                mem_haddr_o     = cpu_haddr_i;
                mem_hwrite_o    = cpu_hwrite_i;
                mem_hsize_o     = cpu_hsize_i;
                mem_hburst_o    = cpu_hburst_i;
                mem_hprot_o     = cpu_hprot_i;
                mem_htrans_o    = cpu_htrans_i;
                mem_hmastlock_o = cpu_hmastlock_i;
            end
            ST_MAM: begin
                mem_hsel_o      = mam_hsel_i;
                mem_haddr_o     = mam_haddr_i;
                mem_hwrite_o    = mam_hwrite_i;
                mem_hsize_o     = mam_hsize_i;
                mem_hburst_o    = mam_hburst_i;
                mem_hprot_o     = mam_hprot_i;
                mem_htrans_o    = mam_htrans_i;
                mem_hmastlock_o = mam_hmastlock_i;
            end
            default: ;
        endcase
    end

    // Write data follows the data-phase owner, not the address-phase owner
    always_comb begin
        mem_hwdata_o = '0;
        case (dphase_reg)
            DP_CPU:  mem_hwdata_o = cpu_hwdata_i;
            DP_MAM:  mem_hwdata_o = mam_hwdata_i;
            default: ;
        endcase
    end

    assign req_vec    = {mam_req, cpu_req};
    assign aowner_vec = {state_reg == ST_MAM, state_reg == ST_CPU};
    assign downer_vec = {dphase_reg == DP_MAM, dphase_reg == DP_CPU};

    // Response routing per master: owners see the slave, waiting requesters are stalled
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign hready_vec[gi] = !rst_ni ? 1'b1 :
                                    (downer_vec[gi] | aowner_vec[gi]) ? mem_hready_i :
                                    ~req_vec[gi];
            assign hresp_vec[gi]  = downer_vec[gi] & mem_hresp_i;
            assign hrdata_arr[gi] = downer_vec[gi] ? mem_hrdata_i : '0;
        end
    endgenerate

    assign cpu_hready_o = hready_vec[0];
    assign cpu_hresp_o  = hresp_vec[0];
    assign cpu_hrdata_o = hrdata_arr[0];
    assign mam_hready_o = hready_vec[1];
    assign mam_hresp_o  = hresp_vec[1];
    assign mam_hrdata_o = hrdata_arr[1];

endmodule

// File: tb/tb_peripheral_dbg_soc_mam_ahb3_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for peripheral_dbg_soc_mam_ahb3_arbiter.
// A behavioural model tracks who owns the address phase, who owns the data
// phase and how long the MAM has waited, and every output is compared to it
// each cycle. Directed scenarios exercise priority, locked bursts, the hold
// budget, wait states, handover data and reset; a random phase follows.
// Master index 0 is the CPU, index 1 is the MAM.
// ---------------------------------------------------------------------------
module tb_peripheral_dbg_soc_mam_ahb3_arbiter;

    localparam int PLEN = 32;
    localparam int XLEN = 32;
    localparam int SW   = XLEN / 8;
    localparam int HOLD = 4;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR4  = 3'b011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Master-side stimulus
    logic            hsel   [2];
    logic [PLEN-1:0] haddr  [2];
    logic [XLEN-1:0] hwdata [2];
    logic            hwrite [2];
    logic [2:0]      hsize  [2];
    logic [2:0]      hburst [2];
    logic [SW-1:0]   hprot  [2];
    logic [1:0]      htrans [2];
    logic            hlock  [2];

    logic [XLEN-1:0] cpu_hrdata, mam_hrdata;
    logic            cpu_hready, mam_hready, cpu_hresp, mam_hresp;
    logic [XLEN-1:0] o_rdata [2];
    logic            o_ready [2];
    logic            o_resp  [2];

    logic            mem_hsel, mem_hwrite, mem_hlock;
    logic [PLEN-1:0] mem_haddr;
    logic [XLEN-1:0] mem_hwdata;
    logic [2:0]      mem_hsize, mem_hburst;
    logic [SW-1:0]   mem_hprot;
    logic [1:0]      mem_htrans;
    logic [XLEN-1:0] mem_hrdata_i = '0;
    logic            mem_hready_i = 1'b1;
    logic            mem_hresp_i  = 1'b0;
    logic            grant_cpu, grant_mam;

    assign o_rdata[0] = cpu_hrdata;
    assign o_rdata[1] = mam_hrdata;
    assign o_ready[0] = cpu_hready;
    assign o_ready[1] = mam_hready;
    assign o_resp[0]  = cpu_hresp;
    assign o_resp[1]  = mam_hresp;

    peripheral_dbg_soc_mam_ahb3_arbiter #(
        .PLEN(PLEN), .XLEN(XLEN), .CPU_HOLD_MAX(HOLD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_hsel_i(hsel[0]), .cpu_haddr_i(haddr[0]), .cpu_hwdata_i(hwdata[0]),
        .cpu_hwrite_i(hwrite[0]), .cpu_hsize_i(hsize[0]), .cpu_hburst_i(hburst[0]),
        .cpu_hprot_i(hprot[0]), .cpu_htrans_i(htrans[0]), .cpu_hmastlock_i(hlock[0]),
        .cpu_hrdata_o(cpu_hrdata), .cpu_hready_o(cpu_hready), .cpu_hresp_o(cpu_hresp),
        .mam_hsel_i(hsel[1]), .mam_haddr_i(haddr[1]), .mam_hwdata_i(hwdata[1]),
        .mam_hwrite_i(hwrite[1]), .mam_hsize_i(hsize[1]), .mam_hburst_i(hburst[1]),
        .mam_hprot_i(hprot[1]), .mam_htrans_i(htrans[1]), .mam_hmastlock_i(hlock[1]),
        .mam_hrdata_o(mam_hrdata), .mam_hready_o(mam_hready), .mam_hresp_o(mam_hresp),
        .mem_hsel_o(mem_hsel), .mem_haddr_o(mem_haddr), .mem_hwdata_o(mem_hwdata),
        .mem_hwrite_o(mem_hwrite), .mem_hsize_o(mem_hsize), .mem_hburst_o(mem_hburst),
        .mem_hprot_o(mem_hprot), .mem_htrans_o(mem_htrans), .mem_hmastlock_o(mem_hlock),
        .mem_hrdata_i(mem_hrdata_i), .mem_hready_i(mem_hready_i), .mem_hresp_i(mem_hresp_i),
        .grant_cpu_o(grant_cpu), .grant_mam_o(grant_mam)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: owner/data-phase as master index, -1 when nobody
    int m_own  = -1;
    int m_dph  = -1;
    int m_wait = 0;
    int n_own, n_dph, n_wait;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit req(input int m);
        return hsel[m] && htrans[m][1];
    endfunction

    task automatic m_reset();
        m_own  = -1;
        m_dph  = -1;
        m_wait = 0;
    endtask

    task automatic model_check();
        logic [63:0] got_a, exp_a, e_ready;
        chk("grant", 64'({grant_mam, grant_cpu}), 64'({m_own == 1, m_own == 0}));
        if (m_own < 0) begin
            chk("idle_bus", 64'({mem_hsel, mem_htrans}), 64'(0));
        end else begin
            got_a = 64'({mem_hsel, mem_haddr, mem_hwrite, mem_hsize, mem_hburst,
                         mem_hprot, mem_htrans, mem_hlock});
            exp_a = 64'({hsel[m_own], haddr[m_own], hwrite[m_own], hsize[m_own],
                         hburst[m_own], hprot[m_own], htrans[m_own], hlock[m_own]});
            chk("addr_bus", got_a, exp_a);
        end
        chk("hwdata", 64'(mem_hwdata), (m_dph < 0) ? 64'(0) : 64'(hwdata[m_dph]));
        for (int m = 0; m < 2; m++) begin
            if (!rst_n)
                e_ready = 64'(1);
            else if (m_dph == m || m_own == m)
                e_ready = 64'(mem_hready_i);
            else
                e_ready = req(m) ? 64'(0) : 64'(1);
            chk(m == 0 ? "cpu_hready" : "mam_hready", 64'(o_ready[m]), e_ready);
            chk(m == 0 ? "cpu_hrdata" : "mam_hrdata", 64'(o_rdata[m]),
                (m_dph == m) ? 64'(mem_hrdata_i) : 64'(0));
            chk(m == 0 ? "cpu_hresp" : "mam_hresp", 64'(o_resp[m]),
                (m_dph == m) ? 64'(mem_hresp_i) : 64'(0));
        end
    endtask

    task automatic model_next();
        bit r0, r1, bnd;
        int o;
        r0 = req(0);
        r1 = req(1);
        o  = m_own;
        n_own  = o;
        n_dph  = m_dph;
        n_wait = m_wait;
        if (o < 0) begin
            if (mem_hready_i) n_own = r1 ? 1 : (r0 ? 0 : -1);
        end else begin
            bnd = mem_hready_i && !hlock[o] && htrans[o] != 2'b11 && htrans[o] != 2'b01;
            if (bnd) begin
                if (!r0 && !r1)                                n_own = -1;
                else if (o == 1 && r0 && !r1)                  n_own = 0;
                else if (o == 0 && r1 && (!r0 || m_wait == HOLD)) n_own = 1;
            end
        end
        if (n_own == 0 && o != 0) n_wait = 0;
        else if (!r1)             n_wait = 0;
        else if (o == 0)          n_wait = (m_wait < HOLD) ? m_wait + 1 : HOLD;
        if (mem_hready_i) n_dph = (o >= 0 && req(o)) ? o : -1;
    endtask

    // Compare at the falling edge, then prepare the model's next state
    task automatic sample_cycle();
        @(negedge clk);
        model_check();
        model_next();
        if (mem_hsel && mem_htrans[1] && mem_hready_i)
            $display("xfer t=%0t %s addr=%h %s", $time, grant_cpu ? "cpu" : "mam",
                     mem_haddr, mem_hwrite ? "wr" : "rd");
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst_n) m_reset();
        else begin
            m_own  = n_own;
            m_dph  = n_dph;
            m_wait = n_wait;
        end
        #1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            sample_cycle();
            advance();
        end
    endtask

    task automatic drv(input int m, input logic sel, input logic [1:0] tr,
                       input logic [PLEN-1:0] a, input logic wr, input logic [2:0] bu,
                       input logic lk, input logic [XLEN-1:0] wd);
        hsel[m]   = sel;
        htrans[m] = tr;
        haddr[m]  = a;
        hwrite[m] = wr;
        hsize[m]  = 3'b010;
        hburst[m] = bu;
        hprot[m]  = 4'h3;
        hlock[m]  = lk;
        hwdata[m] = wd;
    endtask

    task automatic quiet(input int m);
        drv(m, 1'b0, T_IDLE, '0, 1'b0, B_SINGLE, 1'b0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        bit done;
        logic [XLEN-1:0] rd;
        quiet(0);
        quiet(1);

        // Reset state, with a request pending on the CPU to prove hready is forced
        drv(0, 1'b1, T_NSEQ, 32'h0000_0100, 1'b0, B_SINGLE, 1'b0, '0);
        mem_hrdata_i = 32'hDEAD_BEEF;
        mem_hresp_i  = 1'b1;
        #1;
        chk("rst_hready", 64'({cpu_hready, mam_hready}), 64'(2'b11));
        chk("rst_grant", 64'({grant_cpu, grant_mam}), 64'(0));
        cyc(3);
        quiet(0);
        mem_hresp_i = 1'b0;
        rst_n = 1'b1;
        cyc(2);

        // Simultaneous NONSEQ in IDLE: MAM first, CPU waits for MAM to go idle
        drv(0, 1'b1, T_NSEQ, 32'h0000_1000, 1'b0, B_SINGLE, 1'b0, 32'h1111_1111);
        drv(1, 1'b1, T_NSEQ, 32'h0000_2000, 1'b0, B_SINGLE, 1'b0, 32'h2222_2222);
        mem_hrdata_i = $urandom;
        sample_cycle();
        chk("s1_both_stall", 64'({cpu_hready, mam_hready}), 64'(0));
        advance();
        sample_cycle();
        chk("s1_mam_grant", 64'({grant_mam, grant_cpu}), 64'(2'b10));
        chk("s1_mam_addr", 64'(mem_haddr), 64'(32'h0000_2000));
        chk("s1_cpu_stall", 64'(cpu_hready), 64'(0));
        advance();
        quiet(1);
        sample_cycle();
        chk("s1_cpu_stall2", 64'(cpu_hready), 64'(0));
        advance();
        sample_cycle();
        chk("s1_cpu_grant", 64'({grant_mam, grant_cpu}), 64'(2'b01));
        chk("s1_cpu_addr", 64'(mem_haddr), 64'(32'h0000_1000));
        advance();
        quiet(0);
        cyc(3);

        // Locked INCR4 from the MAM keeps the CPU out until the lock drops
        first = -1;
        done  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            case (c)
                0, 1:    drv(1, 1'b1, T_NSEQ, 32'h3000, 1'b1, B_INCR4, 1'b1, 32'hD000_0000);
                2:       drv(1, 1'b1, T_SEQ,  32'h3004, 1'b1, B_INCR4, 1'b1, 32'hD000_0001);
                3:       drv(1, 1'b1, T_SEQ,  32'h3008, 1'b1, B_INCR4, 1'b1, 32'hD000_0002);
                4:       drv(1, 1'b1, T_SEQ,  32'h300C, 1'b1, B_INCR4, 1'b1, 32'hD000_0003);
                5:       drv(1, 1'b1, T_IDLE, 32'h300C, 1'b1, B_INCR4, 1'b1, 32'hD000_0004);
                default: quiet(1);
            endcase
            if (done) quiet(0);
            else drv(0, 1'b1, T_NSEQ, 32'h0000_1100, 1'b0, B_SINGLE, 1'b0, '0);
            sample_cycle();
            if (first < 0 && grant_cpu) first = c;
            if (first < 0) chk("s2_cpu_stall", 64'(cpu_hready), 64'(0));
            if (grant_cpu && cpu_hready) done = 1'b1;
            advance();
        end
        chk("s2_grant_cycle", 64'(first), 64'(7));
        quiet(0);
        quiet(1);
        cyc(2);

        // CPU back-to-back singles; MAM wins once it has waited HOLD cycles
        first = -1;
        done  = 1'b0;
        begin
            int k;
            k = 0;
            for (int c = 0; c < 16; c++) begin
                if (first >= 0 && c > first + 2) quiet(0);
                else drv(0, 1'b1, T_NSEQ, 32'h4000 + 32'(4 * k), 1'b0, B_SINGLE, 1'b0, '0);
                if (c == 0 || done) quiet(1);
                else drv(1, 1'b1, T_NSEQ, 32'h0000_8000, 1'b1, B_SINGLE, 1'b0, 32'h8888_0000);
                sample_cycle();
                if (first < 0 && grant_mam) first = c;
                if (c > 0 && first < 0) chk("s3_mam_stall", 64'(mam_hready), 64'(0));
                if (grant_cpu && cpu_hready && req(0)) k++;
                if (grant_mam && mam_hready && req(1)) done = 1'b1;
                advance();
            end
        end
        chk("s3_grant_cycle", 64'(first), 64'(6));
        quiet(0);
        quiet(1);
        cyc(2);

        // Wait states during a CPU read: response routed to the CPU only
        rd = $urandom | 32'h1;
        drv(0, 1'b1, T_NSEQ, 32'h5000, 1'b0, B_SINGLE, 1'b0, '0);
        cyc(1);
        cyc(1);
        quiet(0);
        drv(1, 1'b1, T_NSEQ, 32'h9000, 1'b0, B_SINGLE, 1'b0, '0);
        mem_hrdata_i = rd;
        for (int c = 0; c < 4; c++) begin
            mem_hready_i = (c == 3);
            sample_cycle();
            chk("s4_grant_held", 64'({grant_mam, grant_cpu}), 64'(2'b01));
            chk("s4_cpu_rdata", 64'(cpu_hrdata), 64'(rd));
            chk("s4_cpu_hready", 64'(cpu_hready), 64'(c == 3));
            chk("s4_mam_rdata", 64'(mam_hrdata), 64'(0));
            advance();
        end
        mem_hready_i = 1'b1;
        sample_cycle();
        chk("s4_mam_grant", 64'(grant_mam), 64'(1));
        advance();
        quiet(1);
        cyc(2);

        // MAM write then CPU read: hwdata stays with the MAM during the handover
        drv(1, 1'b1, T_NSEQ, 32'h6000, 1'b1, B_SINGLE, 1'b0, '0);
        cyc(1);
        drv(0, 1'b1, T_NSEQ, 32'h0000_1200, 1'b0, B_SINGLE, 1'b0, 32'h00C0_FFEE);
        cyc(1);
        drv(1, 1'b0, T_IDLE, 32'h6000, 1'b0, B_SINGLE, 1'b0, 32'hA5A5_0001);
        sample_cycle();
        chk("s5_hwdata_mam", 64'(mem_hwdata), 64'(32'hA5A5_0001));
        chk("s5_cpu_waiting", 64'(cpu_hready), 64'(0));
        advance();
        sample_cycle();
        chk("s5_cpu_grant", 64'(grant_cpu), 64'(1));
        chk("s5_cpu_addr", 64'(mem_haddr), 64'(32'h0000_1200));
        advance();
        quiet(0);
        quiet(1);
        cyc(2);

        // Reset in the middle of a MAM burst takes effect without a clock edge
        drv(1, 1'b1, T_NSEQ, 32'h7000, 1'b1, B_INCR4, 1'b0, '0);
        cyc(2);
        drv(1, 1'b1, T_SEQ, 32'h7004, 1'b1, B_INCR4, 1'b0, 32'h7777_0001);
        mem_hrdata_i = 32'h1234_5678;
        mem_hresp_i  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("s6_grant", 64'({grant_cpu, grant_mam}), 64'(0));
        chk("s6_bus", 64'({mem_hsel, mem_htrans}), 64'(0));
        chk("s6_hready", 64'({cpu_hready, mam_hready}), 64'(2'b11));
        chk("s6_resp", 64'({cpu_hresp, mam_hresp, cpu_hrdata, mam_hrdata}), 64'(0));
        cyc(2);
        quiet(1);
        mem_hresp_i = 1'b0;
        rst_n = 1'b1;
        cyc(2);

        // Random traffic with occasional reset pulses
        for (int c = 0; c < 600; c++) begin
            for (int m = 0; m < 2; m++) begin
                drv(m, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                    1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    $urandom_range(0, 4) == 0, $urandom);
                hsize[m] = 3'($urandom_range(0, 2));
                hprot[m] = 4'($urandom_range(0, 15));
            end
            mem_hready_i = $urandom_range(0, 3) != 0;
            mem_hrdata_i = $urandom;
            mem_hresp_i  = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                m_reset();
            end else begin
                rst_n = 1'b1;
            end
            sample_cycle();
            advance();
        end
        rst_n = 1'b1;
        quiet(0);
        quiet(1);
        mem_hready_i = 1'b1;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
